// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use stall unit for the pipelined MIPS core.
// Tracks in-flight destinations in a private shadow pipeline (EX plus DEPTH older stages).
module fwd_hazard_unit #(
    parameter int REG_AW   = 5,
    parameter int DEPTH    = 2,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16,
    parameter int SELW     = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              id_rs_used_i,
    input  logic              id_rt_used_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              flush_i,
    output logic              stall_o,
    output logic [SELW-1:0]   fa_sel_o,
    output logic [SELW-1:0]   fb_sel_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    localparam int unsigned DEPTH_U = DEPTH;
    localparam int unsigned LAT_U   = LOAD_LAT;

    typedef struct packed {
        logic              valid;
        logic              regwrite;
        logic              memread;
        logic [REG_AW-1:0] rd;
    } dst_t;

    typedef struct packed {
        dst_t              dst;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic              rs_used;
        logic              rt_used;
    } ex_t;

    // Only the EX record keeps its source fields; older stages are only ever producers.
    ex_t              ex_q;
    dst_t             old_q [1:DEPTH];
    dst_t             pos   [0:DEPTH];
    ex_t              id_rec;
    logic             accept;
    logic [CNT_W-1:0] cnt_q;

    logic             a_found, b_found, a_ready, b_ready, a_need, b_need;
    logic [SELW-1:0]  a_near, b_near;
    logic             a_seen, b_seen, a_lu, b_lu;

    function automatic logic writes(dst_t d, logic [REG_AW-1:0] r);
        return d.valid && d.regwrite && (d.rd != '0) && (d.rd == r);
    endfunction

    always_comb begin
        pos[0] = ex_q.dst;
        for (int unsigned k = 1; k <= DEPTH_U; k++) begin
            pos[k] = old_q[k];
        end
    end

    always_comb begin
        a_found = 1'b0;
        b_found = 1'b0;
        a_ready = 1'b0;
        b_ready = 1'b0;
        a_near  = '0;
        b_near  = '0;
        for (int unsigned k = 1; k <= DEPTH_U; k++) begin
            if (!a_found && writes(pos[k], ex_q.rs)) begin
                a_found = 1'b1;
                a_near  = SELW'(k);
                a_ready = !pos[k].memread || (k > LAT_U);
            end
            if (!b_found && writes(pos[k], ex_q.rt)) begin
                b_found = 1'b1;
                b_near  = SELW'(k);
                b_ready = !pos[k].memread || (k > LAT_U);
            end
        end
        a_need   = ex_q.dst.valid && ex_q.rs_used && a_found;
        b_need   = ex_q.dst.valid && ex_q.rt_used && b_found;
        fa_sel_o = (a_need && a_ready) ? a_near : '0;
        fb_sel_o = (b_need && b_ready) ? b_near : '0;
    end

    // Position j becomes stage j+1 once ID moves into EX.
    always_comb begin
        a_seen = 1'b0;
        b_seen = 1'b0;
        a_lu   = 1'b0;
        b_lu   = 1'b0;
        for (int unsigned j = 0; j < DEPTH_U; j++) begin
            if (!a_seen && writes(pos[j], id_rs_i)) begin
                a_seen = 1'b1;
                a_lu   = pos[j].memread && (j < LAT_U);
            end
            if (!b_seen && writes(pos[j], id_rt_i)) begin
                b_seen = 1'b1;
                b_lu   = pos[j].memread && (j < LAT_U);
            end
        end
        stall_o = id_valid_i && !flush_i &&
                  ((id_rs_used_i && a_lu) || (id_rt_used_i && b_lu));
    end

    always_comb begin
        id_rec.dst.valid    = 1'b1;
        id_rec.dst.regwrite = id_regwrite_i;
        id_rec.dst.memread  = id_memread_i;
        id_rec.dst.rd       = id_rd_i;
        id_rec.rs           = id_rs_i;
        id_rec.rt           = id_rt_i;
        id_rec.rs_used      = id_rs_used_i;
        id_rec.rt_used      = id_rt_used_i;
        accept              = id_valid_i && !stall_o && !flush_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_q <= '0;
            for (int unsigned k = 1; k <= DEPTH_U; k++) begin
                old_q[k] <= '0;
            end
            cnt_q <= '0;
        end else begin
            old_q[1] <= ex_q.dst;
            for (int unsigned k = 2; k <= DEPTH_U; k++) begin
                old_q[k] <= old_q[k-1];
            end
            ex_q <= accept ? id_rec : '0;
            if (stall_o && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign stall_cnt_o = cnt_q;

    a_fwd_ready: assert property (@(posedge clk_i) disable iff (rst_i) !(a_need && !a_ready));
    b_fwd_ready: assert property (@(posedge clk_i) disable iff (rst_i) !(b_need && !b_ready));

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: two configurations (2/1/16 and 3/2/4) share one
// ID stream; a history-based reference model predicts every output each cycle.
module tb_fwd_hazard_unit;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, id_valid, rs_used, rt_used, regwrite, memread, flush;
    logic [4:0] rs, rt, rd;
    logic       stall0, stall1;
    logic [1:0] fa0, fb0, fa1, fb1;
    logic [15:0] cnt0;
    logic [3:0]  cnt1;

    fwd_hazard_unit #(.REG_AW(5), .DEPTH(2), .LOAD_LAT(1), .CNT_W(16)) dut0 (
        .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_rs_i(rs), .id_rt_i(rt),
        .id_rs_used_i(rs_used), .id_rt_used_i(rt_used), .id_regwrite_i(regwrite),
        .id_memread_i(memread), .id_rd_i(rd), .flush_i(flush), .stall_o(stall0),
        .fa_sel_o(fa0), .fb_sel_o(fb0), .stall_cnt_o(cnt0)
    );

    fwd_hazard_unit #(.REG_AW(5), .DEPTH(3), .LOAD_LAT(2), .CNT_W(4)) dut1 (
        .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_rs_i(rs), .id_rt_i(rt),
        .id_rs_used_i(rs_used), .id_rt_used_i(rt_used), .id_regwrite_i(regwrite),
        .id_memread_i(memread), .id_rd_i(rd), .flush_i(flush), .stall_o(stall1),
        .fa_sel_o(fa1), .fb_sel_o(fb1), .stall_cnt_o(cnt1)
    );

    typedef struct {
        bit valid, rw, mr, rsu, rtu;
        int rd, rs, rt;
    } rec_t;

    typedef struct {
        int s0, s1, a0, a1, b0, b1, c0, c1;
    } exp_t;

    localparam int D    [2] = '{2, 3};
    localparam int LAT  [2] = '{1, 2};
    localparam int CMAX [2] = '{65535, 15};

    // hist[i][k] = instruction that entered EX k cycles ago in configuration i
    rec_t hist [2][4];
    int   cnt  [2];
    exp_t sb_q [$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(string name, int got, int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    function automatic rec_t mk(bit v, int rs_, int rt_, bit rsu, bit rtu, bit rw, bit mr, int rd_);
        rec_t r;
        r.valid = v; r.rs = rs_; r.rt = rt_; r.rsu = rsu; r.rtu = rtu;
        r.rw = rw; r.mr = mr; r.rd = rd_;
        return r;
    endfunction

    function automatic bit produces(rec_t r, int regno);
        return r.valid && r.rw && (r.rd != 0) && (r.rd == regno);
    endfunction

    // Which stage the EX consumer reads from: nearest producer, 0 if none or data not yet there.
    function automatic int model_sel(int i, bit use_rs);
        rec_t c = hist[i][0];
        int   src = use_rs ? c.rs : c.rt;
        bit   used = use_rs ? c.rsu : c.rtu;
        if (!c.valid || !used) return 0;
        for (int k = 1; k <= D[i]; k++) begin
            if (produces(hist[i][k], src))
                return (!hist[i][k].mr || k > LAT[i]) ? k : 0;
        end
        return 0;
    endfunction

    // Would the nearest producer of src still be a load whose data is too young?
    function automatic bit young_load(int i, int src);
        for (int j = 0; j < D[i]; j++) begin
            if (produces(hist[i][j], src))
                return hist[i][j].mr && (j < LAT[i]);
        end
        return 0;
    endfunction

    function automatic bit model_stall(int i, rec_t id, bit fl);
        if (!id.valid || fl) return 0;
        return (id.rsu && young_load(i, id.rs)) || (id.rtu && young_load(i, id.rt));
    endfunction

    task automatic clear_model();
        rec_t bub = '{default: 0};
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 4; k++) hist[i][k] = bub;
            cnt[i] = 0;
        end
    endtask

    task automatic issue(rec_t id, bit fl, bit r);
        exp_t e;
        int   st [2];
        rec_t bub = '{default: 0};
        id_valid = id.valid; rs = 5'(id.rs); rt = 5'(id.rt);
        rs_used = id.rsu; rt_used = id.rtu; regwrite = id.rw; memread = id.mr;
        rd = 5'(id.rd); flush = fl; rst = r;
        for (int i = 0; i < 2; i++) st[i] = model_stall(i, id, fl);
        e.s0 = st[0]; e.s1 = st[1];
        e.a0 = model_sel(0, 1); e.b0 = model_sel(0, 0);
        e.a1 = model_sel(1, 1); e.b1 = model_sel(1, 0);
        e.c0 = cnt[0]; e.c1 = cnt[1];
        sb_q.push_back(e);
        @(posedge clk);
        if (r) begin
            clear_model();
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (st[i] != 0 && cnt[i] < CMAX[i]) cnt[i]++;
                for (int k = D[i]; k >= 1; k--) hist[i][k] = hist[i][k-1];
                hist[i][0] = (id.valid && st[i] == 0 && !fl) ? id : bub;
            end
        end
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("stall0", int'(stall0), e.s0);
                check("fa0",    int'(fa0),    e.a0);
                check("fb0",    int'(fb0),    e.b0);
                check("cnt0",   int'(cnt0),   e.c0);
                check("stall1", int'(stall1), e.s1);
                check("fa1",    int'(fa1),    e.a1);
                check("fb1",    int'(fb1),    e.b1);
                check("cnt1",   int'(cnt1),   e.c1);
            end
        end
    end

    initial begin : driver
        rec_t nop, id;
        nop = mk(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1; id_valid = 1'b0; rs = '0; rt = '0; rd = '0;
        rs_used = 1'b0; rt_used = 1'b0; regwrite = 1'b0; memread = 1'b0; flush = 1'b0;
        @(posedge clk);
        #1;
        clear_model();
        issue(nop, 0, 1);

        // add r3 then add r4,r3,r3
        issue(mk(1, 1, 2, 1, 1, 1, 0, 3), 0, 0);
        issue(mk(1, 3, 3, 1, 1, 1, 0, 4), 0, 0);
        issue(nop, 0, 0);
        issue(nop, 0, 0);
        // add r5, sub r5, consumer of r5
        issue(mk(1, 1, 1, 1, 1, 1, 0, 5), 0, 0);
        issue(mk(1, 2, 2, 1, 1, 1, 0, 5), 0, 0);
        issue(mk(1, 5, 0, 1, 1, 1, 0, 6), 0, 0);
        issue(nop, 0, 0);
        // lw r2, then add r6,r2,r0 held in ID
        issue(mk(1, 1, 0, 1, 0, 1, 1, 2), 0, 0);
        repeat (3) issue(mk(1, 2, 0, 1, 1, 1, 0, 6), 0, 0);
        issue(nop, 0, 0);
        issue(nop, 0, 0);
        // lw r7, add r7, consumer of r7
        issue(mk(1, 1, 0, 1, 0, 1, 1, 7), 0, 0);
        issue(mk(1, 1, 1, 1, 1, 1, 0, 7), 0, 0);
        issue(mk(1, 7, 7, 1, 1, 1, 0, 8), 0, 0);
        issue(nop, 0, 0);
        issue(nop, 0, 0);
        // writer to r0 with r0 consumer
        issue(mk(1, 1, 1, 1, 1, 1, 0, 0), 0, 0);
        issue(mk(1, 0, 0, 1, 1, 1, 0, 9), 0, 0);
        // load-use killed by flush
        issue(mk(1, 1, 0, 1, 0, 1, 1, 2), 0, 0);
        issue(mk(1, 2, 2, 1, 1, 1, 0, 6), 1, 0);
        issue(nop, 0, 0);
        // reset in the middle of a stall
        issue(mk(1, 1, 0, 1, 0, 1, 1, 7), 0, 0);
        issue(mk(1, 7, 0, 1, 0, 1, 0, 8), 0, 0);
        issue(mk(1, 7, 0, 1, 0, 1, 0, 8), 0, 1);
        issue(mk(1, 7, 0, 1, 0, 1, 0, 8), 0, 0);
        issue(nop, 0, 0);
        // back-to-back lw r1,(r1): drives the 4-bit counter into saturation
        repeat (50) issue(mk(1, 1, 0, 1, 0, 1, 1, 1), 0, 0);

        for (int n = 0; n < 3000; n++) begin
            id.valid = ($urandom_range(0, 9) != 0);
            id.rs    = $urandom_range(0, 3);
            id.rt    = $urandom_range(0, 3);
            id.rsu   = $urandom_range(0, 3) != 0;
            id.rtu   = $urandom_range(0, 1);
            id.rw    = $urandom_range(0, 9) < 7;
            id.mr    = $urandom_range(0, 9) < 4;
            id.rd    = $urandom_range(0, 3);
            issue(id, $urandom_range(0, 19) == 0, $urandom_range(0, 299) == 0);
        end

        issue(nop, 0, 0);
        @(negedge clk);
        #1;
        check("drain", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
